stream_rev_arb: RTL and testbench

- Shares one streaming-operator reversal datapath between two requesters.
- Applies SystemVerilog `{<< s {x}}` (slice reversal) or `{>> s {x}}` (identity) per beat, with a run-time slice size.
- Round-robin arbitration with packet lock, valid/ready on every port, one registered output stage.
- Sits between producers of packed words and any consumer that needs bit/slice reordering at run time rather than elaboration time.

---
 rtl/stream_rev_pkg.sv | 16 +
 rtl/stream_slice_rev.sv | 43 ++++
 rtl/stream_rev_arb.sv | 114 +++++++++++
 tb/tb_stream_rev_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rev_pkg.sv
// rtl/stream_rev_pkg.sv - shared types and constants for the slice-reversal arbiter
package stream_rev_pkg;

   localparam int DEF_W  = 32;
   localparam int DEF_SW = 8;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      LOCK0,
      LOCK1
   } arb_state_t;

endpackage

// File: rtl/stream_slice_rev.sv
// rtl/stream_slice_rev.sv - combinational run-time slice reversal ({<< s {x}} or identity)
module stream_slice_rev
   import stream_rev_pkg::*;
#(
   parameter int W  = DEF_W,
   parameter int SW = DEF_SW
) (
   input  logic [W-1:0]  data,
   input  logic [SW-1:0] slice,
   input  logic          dir,
   output logic [W-1:0]  result
);

   int s;
   int base;
   int off;
   int len;
   int dst;

   // Walk input bits LSB-first, tracking which slice each belongs to; the
   // slice starting at input bit base lands ending at output bit W-1-base.
   always_comb begin
      s      = (slice == '0) ? 1 : int'(slice);
      base   = 0;
      off    = 0;
      len    = 0;
      dst    = 0;
      result = '0;
      for (int i = 0; i < W; i++) begin
         if (off == s) begin
            base = base + s;
            off  = 0;
         end
         len = ((W - base) < s) ? (W - base) : s;
         dst = (dir == DIR_LEFT) ? (W - base - len + off) : i;
         for (int o = 0; o < W; o++) begin
            if (dst == o) result[o] = data[i];
         end
         off = off + 1;
      end
   end

endmodule

// File: rtl/stream_rev_arb.sv
// rtl/stream_rev_arb.sv - two-requester round-robin arbiter with packet lock in front of a shared slice reverser
module stream_rev_arb
   import stream_rev_pkg::*;
#(
   parameter int W  = DEF_W,
   parameter int SW = DEF_SW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in0_valid,
   output logic          in0_ready,
   input  logic [W-1:0]  in0_data,
   input  logic [SW-1:0] in0_slice,
   input  logic          in0_dir,
   input  logic          in0_last,
   input  logic          in1_valid,
   output logic          in1_ready,
   input  logic [W-1:0]  in1_data,
   input  logic [SW-1:0] in1_slice,
   input  logic          in1_dir,
   input  logic          in1_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_src,
   output logic          out_last,
   output logic          slice_err
);

   arb_state_t    state;
   logic          rr_ptr;
   logic          can_load;
   logic          gnt;
   logic          gnt_ok;
   logic          accept;
   logic [W-1:0]  sel_data;
   logic [SW-1:0] sel_slice;
   logic          sel_dir;
   logic          sel_last;
   logic [W-1:0]  rev_data;

   assign can_load = !out_valid || out_ready;

   // A locked packet owns the datapath even while its producer bubbles.
   always_comb begin
      gnt    = 1'b0;
      gnt_ok = 1'b0;
      case (state)
         LOCK0: begin
            gnt    = 1'b0;
            gnt_ok = 1'b1;
         end
         LOCK1: begin
            gnt    = 1'b1;
            gnt_ok = 1'b1;
         end
         default: begin
            if (in0_valid && in1_valid) begin
               gnt    = rr_ptr;
               gnt_ok = 1'b1;
            end else if (in1_valid) begin
               gnt    = 1'b1;
               gnt_ok = 1'b1;
            end else if (in0_valid) begin
               gnt    = 1'b0;
               gnt_ok = 1'b1;
            end
         end
      endcase
   end

   assign in0_ready = can_load && gnt_ok && !gnt;
   assign in1_ready = can_load && gnt_ok && gnt;
   assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);

   assign sel_data  = gnt ? in1_data  : in0_data;
   assign sel_slice = gnt ? in1_slice : in0_slice;
   assign sel_dir   = gnt ? in1_dir   : in0_dir;
   assign sel_last  = gnt ? in1_last  : in0_last;

   stream_slice_rev #(.W(W), .SW(SW)) u_rev (
      .data   (sel_data),
      .slice  (sel_slice),
      .dir    (sel_dir),
      .result (rev_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
         out_last  <= 1'b0;
         slice_err <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= rev_data;
         out_src   <= gnt;
         out_last  <= sel_last;
         if (sel_slice == '0) slice_err <= 1'b1;
         if (sel_last) begin
            state  <= IDLE;
            rr_ptr <= !gnt;
         end else begin
            state  <= gnt ? LOCK1 : LOCK0;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_rev_arb.sv
// tb/tb_stream_rev_arb.sv - randomized scoreboard bench for stream_rev_arb plus directed slice vectors
module tb_stream_rev_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // W=32 main instance
   logic        m0_valid, m0_ready, m0_dir, m0_last;
   logic [31:0] m0_data;
   logic [7:0]  m0_slice;
   logic        m1_valid, m1_ready, m1_dir, m1_last;
   logic [31:0] m1_data;
   logic [7:0]  m1_slice;
   logic        m_out_valid, m_out_ready, m_out_src, m_out_last, m_slice_err;
   logic [31:0] m_out_data;

   // W=4 and W=23 instances, requester 0 only
   logic        s4_valid, s4_ready, s4_in1_ready, s4_out_valid, s4_out_src, s4_out_last, s4_err;
   logic [3:0]  s4_data, s4_out_data;
   logic        s23_valid, s23_ready, s23_in1_ready, s23_out_valid, s23_out_src, s23_out_last, s23_err;
   logic [22:0] s23_data, s23_out_data;
   logic [7:0]  s_slice;
   logic        s_dir;

   stream_rev_arb #(.W(32), .SW(8)) dut (
      .clk(clk), .rst(rst),
      .in0_valid(m0_valid), .in0_ready(m0_ready), .in0_data(m0_data),
      .in0_slice(m0_slice), .in0_dir(m0_dir), .in0_last(m0_last),
      .in1_valid(m1_valid), .in1_ready(m1_ready), .in1_data(m1_data),
      .in1_slice(m1_slice), .in1_dir(m1_dir), .in1_last(m1_last),
      .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
      .out_src(m_out_src), .out_last(m_out_last), .slice_err(m_slice_err)
   );

   stream_rev_arb #(.W(4), .SW(8)) dut4 (
      .clk(clk), .rst(rst),
      .in0_valid(s4_valid), .in0_ready(s4_ready), .in0_data(s4_data),
      .in0_slice(s_slice), .in0_dir(s_dir), .in0_last(1'b1),
      .in1_valid(1'b0), .in1_ready(s4_in1_ready), .in1_data(4'h0),
      .in1_slice(8'h0), .in1_dir(1'b0), .in1_last(1'b0),
      .out_valid(s4_out_valid), .out_ready(1'b1), .out_data(s4_out_data),
      .out_src(s4_out_src), .out_last(s4_out_last), .slice_err(s4_err)
   );

   stream_rev_arb #(.W(23), .SW(8)) dut23 (
      .clk(clk), .rst(rst),
      .in0_valid(s23_valid), .in0_ready(s23_ready), .in0_data(s23_data),
      .in0_slice(s_slice), .in0_dir(s_dir), .in0_last(1'b1),
      .in1_valid(1'b0), .in1_ready(s23_in1_ready), .in1_data(23'h0),
      .in1_slice(8'h0), .in1_dir(1'b0), .in1_last(1'b0),
      .out_valid(s23_out_valid), .out_ready(1'b1), .out_data(s23_out_data),
      .out_src(s23_out_src), .out_last(s23_out_last), .slice_err(s23_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Chunks cut from the LSB end; chunk 0 goes to the top, later chunks stack below it.
   function automatic logic [127:0] rev_ref(input logic [127:0] x, input int w, input int sl, input logic d);
      logic [127:0] r;
      int s, pos, start, len;
      if (!d) return x;
      s     = (sl == 0) ? 1 : sl;
      r     = '0;
      pos   = w;
      start = 0;
      while (start < w) begin
         len = ((w - start) < s) ? (w - start) : s;
         pos = pos - len;
         for (int b = 0; b < len; b++) r[pos + b] = x[start + b];
         start = start + len;
      end
      return r;
   endfunction

   task automatic small_beat(input logic [7:0] sl, input logic d, input logic [3:0] d4, input logic [3:0] e4,
                             input logic [22:0] d23, input logic [22:0] e23);
      @(posedge clk); #1;
      s_slice = sl; s_dir = d; s4_data = d4; s23_data = d23;
      s4_valid = 1'b1; s23_valid = 1'b1;
      @(negedge clk);
      check("s4_ready", 128'(s4_ready), 128'(1'b1));
      check("s4_pre_valid", 128'(s4_out_valid), 128'(1'b0));
      check("s23_ready", 128'(s23_ready), 128'(1'b1));
      @(posedge clk); #1;
      s4_valid = 1'b0; s23_valid = 1'b0;
      @(negedge clk);
      check("s4_valid", 128'(s4_out_valid), 128'(1'b1));
      check("s4_data", 128'(s4_out_data), 128'(e4));
      check("s4_last", 128'(s4_out_last), 128'(1'b1));
      check("s23_valid", 128'(s23_out_valid), 128'(1'b1));
      check("s23_data", 128'(s23_out_data), 128'(e23));
   endtask

   task automatic main_beat(input logic [31:0] d, input logic [7:0] sl, input logic [31:0] e);
      @(posedge clk); #1;
      m0_data = d; m0_slice = sl; m0_dir = 1'b1; m0_last = 1'b1; m0_valid = 1'b1;
      @(negedge clk);
      check("m_dir_ready", 128'(m0_ready), 128'(1'b1));
      @(posedge clk); #1;
      m0_valid = 1'b0;
      @(negedge clk);
      check("m_dir_valid", 128'(m_out_valid), 128'(1'b1));
      check("m_dir_data", 128'(m_out_data), 128'(e));
      check("m_dir_src", 128'(m_out_src), 128'(1'b0));
   endtask

   // Per-requester packet generators
   logic [31:0] g_data [2];
   logic [7:0]  g_slice[2];
   logic        g_dir  [2];
   logic        g_last [2];
   logic        pend   [2];
   logic        vld    [2];
   int          left   [2];

   task automatic new_beat(input int n);
      if (left[n] == 0) left[n] = $urandom_range(1, 4);
      g_data[n]  = $urandom;
      if ($urandom_range(0, 39) == 0)     g_slice[n] = 8'd0;
      else if ($urandom_range(0, 3) == 0) g_slice[n] = 8'($urandom_range(0, 255));
      else                                g_slice[n] = 8'($urandom_range(1, 9));
      g_dir[n]   = 1'($urandom_range(0, 1));
      g_last[n]  = (left[n] == 1);
      pend[n]    = 1'b1;
   endtask

   // Reference model state
   int          m_lock;      // 0 = idle, 1 = locked to 0, 2 = locked to 1
   logic        m_rr;
   logic        e_valid, e_src, e_last, e_err;
   logic [31:0] e_data;
   logic        cl, ok, g, er0, er1;
   int          n;
   logic        rst_now, rst_done, force_both;

   initial begin
      rst = 1'b1;
      m0_valid = 0; m0_data = 0; m0_slice = 0; m0_dir = 0; m0_last = 0;
      m1_valid = 0; m1_data = 0; m1_slice = 0; m1_dir = 0; m1_last = 0;
      m_out_ready = 1'b1;
      s4_valid = 0; s4_data = 0; s23_valid = 0; s23_data = 0; s_slice = 0; s_dir = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 128'(m_out_valid), 128'(1'b0));
      check("rst_out_data", 128'(m_out_data), 128'(32'h0));
      check("rst_out_src", 128'(m_out_src), 128'(1'b0));
      check("rst_out_last", 128'(m_out_last), 128'(1'b0));
      check("rst_slice_err", 128'(m_slice_err), 128'(1'b0));
      rst = 1'b0;

      // Directed slice vectors: slice, dir, W=4 in/out, W=23 in/out
      small_beat(8'd1, 1'b1, 4'h1, 4'h8, 23'h1, 23'h400000);
      small_beat(8'd2, 1'b1, 4'h1, 4'h4, 23'h1, 23'h200000);
      small_beat(8'd3, 1'b1, 4'h1, 4'h2, 23'h1, 23'h100000);
      small_beat(8'd4, 1'b1, 4'h1, 4'h1, 23'h1, 23'h080000);
      small_beat(8'd5, 1'b1, 4'h1, 4'h1, 23'h1, 23'h040000);
      small_beat(8'd3, 1'b1, 4'h1, 4'h2, 23'h7FFFFF, 23'h7FFFFF);
      for (int sl = 1; sl <= 5; sl++) small_beat(8'(sl), 1'b0, 4'h1, 4'h1, 23'h05A5A5, 23'h05A5A5);
      check("s4_err_before", 128'(s4_err), 128'(1'b0));
      small_beat(8'd0, 1'b1, 4'h1, 4'h8, 23'h1, 23'h400000);
      check("s4_err_set", 128'(s4_err), 128'(1'b1));
      small_beat(8'd2, 1'b1, 4'h1, 4'h4, 23'h1, 23'h200000);
      check("s4_err_sticky", 128'(s4_err), 128'(1'b1));

      main_beat(32'h04030201, 8'd1, 32'h8040C020);
      main_beat(32'h04030201, 8'd8, 32'h01020304);
      main_beat(32'h04030201, 8'd40, 32'h04030201);

      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      m_lock = 0; m_rr = 1'b0; e_valid = 0; e_src = 0; e_last = 0; e_err = 0; e_data = 0;
      for (int i = 0; i < 2; i++) begin pend[i] = 0; left[i] = 0; vld[i] = 0; end
      rst_now = 0; rst_done = 0; force_both = 0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         if (rst_now) begin
            rst = 1'b1; #1;
            check("mid_rst_out_valid", 128'(m_out_valid), 128'(1'b0));
            check("mid_rst_slice_err", 128'(m_slice_err), 128'(1'b0));
            check("mid_rst_out_data", 128'(m_out_data), 128'(32'h0));
            m_lock = 0; m_rr = 1'b0; e_valid = 0; e_err = 0;
            for (int i = 0; i < 2; i++) begin pend[i] = 0; left[i] = 0; end
            rst_now = 0; rst_done = 1; force_both = 1;
            @(posedge clk); #1;
            rst = 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            if (!pend[i]) new_beat(i);
            vld[i] = force_both || ($urandom_range(0, 3) != 0);
         end
         m_out_ready = force_both || ($urandom_range(0, 3) != 0);
         force_both = 0;
         m0_valid = vld[0]; m0_data = g_data[0]; m0_slice = g_slice[0]; m0_dir = g_dir[0]; m0_last = g_last[0];
         m1_valid = vld[1]; m1_data = g_data[1]; m1_slice = g_slice[1]; m1_dir = g_dir[1]; m1_last = g_last[1];

         @(negedge clk);
         cl = !e_valid || m_out_ready;
         ok = 1'b1;
         g  = 1'b0;
         if (m_lock == 1)          g = 1'b0;
         else if (m_lock == 2)     g = 1'b1;
         else if (vld[0] && vld[1]) g = m_rr;
         else if (vld[1])          g = 1'b1;
         else if (vld[0])          g = 1'b0;
         else                      ok = 1'b0;
         er0 = cl && ok && !g;
         er1 = cl && ok && g;
         if (ok) begin
            check("in0_ready", 128'(m0_ready), 128'(er0));
            check("in1_ready", 128'(m1_ready), 128'(er1));
         end
         check("out_valid", 128'(m_out_valid), 128'(e_valid));
         if (e_valid) begin
            check("out_data", 128'(m_out_data), 128'(e_data));
            check("out_src", 128'(m_out_src), 128'(e_src));
            check("out_last", 128'(m_out_last), 128'(e_last));
         end
         check("slice_err", 128'(m_slice_err), 128'(e_err));

         if ((er0 && vld[0]) || (er1 && vld[1])) begin
            n = g ? 1 : 0;
            e_valid = 1'b1;
            e_data  = 32'(rev_ref(128'(g_data[n]), 32, int'(g_slice[n]), g_dir[n]));
            e_src   = g;
            e_last  = g_last[n];
            if (g_slice[n] == 8'd0) e_err = 1'b1;
            if (g_last[n]) begin
               m_lock = 0;
               m_rr   = !g;
            end else begin
               m_lock = g ? 2 : 1;
            end
            left[n] = left[n] - 1;
            pend[n] = 1'b0;
         end else if (m_out_ready) begin
            e_valid = 1'b0;
         end
         if (!rst_done && cyc >= 1500 && m_lock == 2) rst_now = 1'b1;
      end
      check("mid_rst_reached", 128'(rst_done), 128'(1'b1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
